ro_scan_sequencer: RTL and testbench

- Sequences measurement of NUM_RO ring-oscillator sensors that share one edge counter.
- Enables one RO at a time, clears and runs the shared counter for a programmed ACLK window, then hands each result to the AXI4-Lite register block over a valid/ready interface.
- Sits between the slave register file (config/status) and the RO array plus counter.

---
 rtl/ro_scan_sequencer_if.sv | 24 ++
 rtl/ro_scan_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_ro_scan_sequencer.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ro_scan_sequencer_if.sv
// ============================================================================
// Module   : ro_scan_sequencer_if
// Purpose  : Result channel (valid/ready) from the RO scan sequencer.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface ro_scan_sequencer_if #(
  parameter int NUM_RO = 4,
  parameter int CNT_W  = 32
);
  localparam int c_IDX_W = $clog2(NUM_RO);

  logic               res_valid;
  logic               res_ready;
  logic [c_IDX_W-1:0] res_idx;
  logic [CNT_W-1:0]   res_data;

  modport master (output res_valid, output res_idx, output res_data, input res_ready);
  modport slave  (input res_valid, input res_idx, input res_data, output res_ready);
endinterface

`default_nettype wire

// File: rtl/ro_scan_sequencer.sv
// ============================================================================
// Module   : ro_scan_sequencer
// Purpose  : Scans NUM_RO ring oscillators through one shared edge counter.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ro_scan_sequencer #(
  parameter int NUM_RO     = 4,
  parameter int CNT_W      = 32,
  parameter int WIN_W      = 16,
  parameter int SETTLE_CYC = 8,
  parameter int SYNC_LAT   = 3
) (
  input  wire logic              ACLK,
  input  wire logic              ARESETN,
  input  wire logic              cfg_start,
  input  wire logic              cfg_stop,
  input  wire logic              cfg_continuous,
  input  wire logic [NUM_RO-1:0] cfg_mask,
  input  wire logic [WIN_W-1:0]  cfg_window,
  output logic      [NUM_RO-1:0] ro_en,
  output logic                   cnt_clear,
  output logic                   cnt_run,
  input  wire logic [CNT_W-1:0]  cnt_value,
  ro_scan_sequencer_if.master    res,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_err
);

  localparam int c_IDX_W = $clog2(NUM_RO);
  localparam int c_SET_W = $clog2(SETTLE_CYC + 1);
  localparam int c_SYN_W = $clog2(SYNC_LAT + 1);
  localparam int c_TMR_A = (WIN_W > c_SET_W) ? WIN_W : c_SET_W;
  localparam int c_TMR_W = (c_TMR_A > c_SYN_W) ? c_TMR_A : c_SYN_W;
  localparam logic [c_TMR_W-1:0] c_SETTLE_LAST = c_TMR_W'(SETTLE_CYC - 1);
  localparam logic [c_TMR_W-1:0] c_SYNC_LAST   = c_TMR_W'(SYNC_LAT);
  localparam logic [c_TMR_W-1:0] c_TMR_ONE     = c_TMR_W'(1);
  localparam logic [NUM_RO-1:0]  c_RO_ONE      = NUM_RO'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_MEASURE = 3'd2,
    S_CAPTURE = 3'd3,
    S_OUTPUT  = 3'd4,
    S_NEXT    = 3'd5
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [c_IDX_W-1:0]  r_idx, w_idx_nxt;
  logic [NUM_RO-1:0]   r_mask, w_mask_nxt;
  logic [WIN_W-1:0]    r_window, w_window_nxt;
  logic [c_TMR_W-1:0]  r_tmr, w_tmr_nxt;
  logic                r_stop_pending, w_stop_nxt;
  logic                r_done, w_done_nxt;
  logic                r_cfg_err, w_err_nxt;
  logic                r_res_valid, w_valid_nxt;
  logic [c_IDX_W-1:0]  r_res_idx, w_ridx_nxt;
  logic [CNT_W-1:0]    r_res_data, w_rdata_nxt;

  logic [NUM_RO-1:0]   w_onehot;
  logic [NUM_RO-1:0]   w_above;
  logic [c_TMR_W-1:0]  w_win_last;

  function automatic logic [c_IDX_W-1:0] f_lowest(input logic [NUM_RO-1:0] m);
    f_lowest = '0;
    for (int i = NUM_RO - 1; i >= 0; i--) begin
      if (m[i]) f_lowest = c_IDX_W'(i);
    end
  endfunction

  assign w_onehot   = c_RO_ONE << r_idx;
  // Mask bits strictly above r_idx; the shift overflows to zero at the top index.
  assign w_above    = r_mask & ~((w_onehot << 1) - c_RO_ONE);
  assign w_win_last = c_TMR_W'(r_window - WIN_W'(1));

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state        <= S_IDLE;
      r_idx          <= '0;
      r_mask         <= '0;
      r_window       <= '0;
      r_tmr          <= '0;
      r_stop_pending <= 1'b0;
      r_done         <= 1'b0;
      r_cfg_err      <= 1'b0;
      r_res_valid    <= 1'b0;
      r_res_idx      <= '0;
      r_res_data     <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_idx          <= w_idx_nxt;
      r_mask         <= w_mask_nxt;
      r_window       <= w_window_nxt;
      r_tmr          <= w_tmr_nxt;
      r_stop_pending <= w_stop_nxt;
      r_done         <= w_done_nxt;
      r_cfg_err      <= w_err_nxt;
      r_res_valid    <= w_valid_nxt;
      r_res_idx      <= w_ridx_nxt;
      r_res_data     <= w_rdata_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_mask_nxt   = r_mask;
    w_window_nxt = r_window;
    w_tmr_nxt    = r_tmr;
    w_stop_nxt   = r_stop_pending | (cfg_stop && (r_state != S_IDLE));
    w_done_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    w_valid_nxt  = r_res_valid;
    w_ridx_nxt   = r_res_idx;
    w_rdata_nxt  = r_res_data;

    unique case (r_state)
      S_IDLE: begin
        if (cfg_start && !cfg_stop) begin
          if ((cfg_window == '0) || (cfg_mask == '0)) begin
            w_err_nxt = 1'b1;
          end else begin
            w_mask_nxt   = cfg_mask;
            w_window_nxt = cfg_window;
            w_idx_nxt    = f_lowest(cfg_mask);
            w_tmr_nxt    = '0;
            w_state_nxt  = S_SETTLE;
          end
        end
      end
      S_SETTLE: begin
        if (cfg_stop) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_tmr == c_SETTLE_LAST) begin
          w_tmr_nxt   = '0;
          w_state_nxt = S_MEASURE;
        end else begin
          w_tmr_nxt   = r_tmr + c_TMR_ONE;
        end
      end
      S_MEASURE: begin
        if (cfg_stop) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_tmr == w_win_last) begin
          w_tmr_nxt   = '0;
          w_state_nxt = S_CAPTURE;
        end else begin
          w_tmr_nxt   = r_tmr + c_TMR_ONE;
        end
      end
      S_CAPTURE: begin
        // The counter output settles SYNC_LAT cycles after the gate closes.
        if (r_tmr == c_SYNC_LAST) begin
          w_valid_nxt = 1'b1;
          w_ridx_nxt  = r_idx;
          w_rdata_nxt = cnt_value;
          w_state_nxt = S_OUTPUT;
        end else begin
          w_tmr_nxt   = r_tmr + c_TMR_ONE;
        end
      end
      S_OUTPUT: begin
        if (res.res_ready) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = S_NEXT;
        end
      end
      S_NEXT: begin
        w_tmr_nxt = '0;
        if (w_stop_nxt) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (|w_above) begin
          w_idx_nxt   = f_lowest(w_above);
          w_state_nxt = S_SETTLE;
        end else if (cfg_continuous) begin
          w_idx_nxt   = f_lowest(r_mask);
          w_state_nxt = S_SETTLE;
        end else begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_state_nxt == S_IDLE) w_stop_nxt = 1'b0;
  end

  assign ro_en         = ((r_state == S_SETTLE) || (r_state == S_MEASURE)) ? w_onehot : '0;
  assign cnt_clear     = (r_state == S_SETTLE);
  assign cnt_run       = (r_state == S_MEASURE);
  assign busy          = (r_state != S_IDLE);
  assign done          = r_done;
  assign cfg_err       = r_cfg_err;
  assign res.res_valid = r_res_valid;
  assign res.res_idx   = r_res_idx;
  assign res.res_data  = r_res_data;

endmodule

`default_nettype wire

// File: tb/tb_ro_scan_sequencer.sv
// ============================================================================
// Module   : tb_ro_scan_sequencer
// Purpose  : Self-checking bench for ro_scan_sequencer with a counter model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ro_scan_sequencer;
  localparam int NUM_RO = 4, CNT_W = 32, WIN_W = 16, SETTLE_CYC = 8, SYNC_LAT = 3;
  typedef int iq_t[$];

  logic ACLK = 1'b0, ARESETN = 1'b0;
  logic cfg_start = 0, cfg_stop = 0, cfg_continuous = 0, res_ready = 0, rnd_ready = 0;
  logic [NUM_RO-1:0] cfg_mask = '0;
  logic [WIN_W-1:0]  cfg_window = '0;
  logic [NUM_RO-1:0] ro_en;
  logic cnt_clear, cnt_run, busy, done, cfg_err;
  logic [CNT_W-1:0] cnt, cnt_d1, cnt_d2, cnt_value;

  int n_checks = 0, n_fails = 0;
  int obs_idx[512], obs_data[512], ro_seq[512];
  int n_obs = 0, n_ro = 0, n_done = 0, n_inv = 0, n_vrise = 0;
  logic prev_v = 1'b0;
  logic [NUM_RO-1:0] prev_ro = '0;

  ro_scan_sequencer_if #(.NUM_RO(NUM_RO), .CNT_W(CNT_W)) ifc ();
  assign ifc.res_ready = res_ready;

  ro_scan_sequencer #(.NUM_RO(NUM_RO), .CNT_W(CNT_W), .WIN_W(WIN_W),
                      .SETTLE_CYC(SETTLE_CYC), .SYNC_LAT(SYNC_LAT)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_continuous(cfg_continuous), .cfg_mask(cfg_mask), .cfg_window(cfg_window),
    .ro_en(ro_en), .cnt_clear(cnt_clear), .cnt_run(cnt_run), .cnt_value(cnt_value),
    .res(ifc), .busy(busy), .done(done), .cfg_err(cfg_err));

  always #5 ACLK = ~ACLK;

  // Shared edge counter with a two-stage output pipeline (shorter than SYNC_LAT).
  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      cnt <= '0; cnt_d1 <= '0; cnt_d2 <= '0;
    end else begin
      if (cnt_clear) cnt <= '0;
      else if (cnt_run) cnt <= cnt + 1;
      cnt_d1 <= cnt;
      cnt_d2 <= cnt_d1;
    end
  end
  assign cnt_value = cnt_d2;

  always @(posedge ACLK) begin
    if (ifc.res_valid && ifc.res_ready && n_obs < 512) begin
      obs_idx[n_obs]  = int'(ifc.res_idx);
      obs_data[n_obs] = int'(ifc.res_data);
      n_obs++;
    end
    if (done) n_done++;
    if (ifc.res_valid && !prev_v) n_vrise++;
    prev_v = ifc.res_valid;
    if (ro_en != prev_ro && ro_en != '0 && n_ro < 512) begin
      ro_seq[n_ro] = int'(ro_en);
      n_ro++;
    end
    prev_ro = ro_en;
    if (!$onehot0(ro_en) || ((ro_en != '0) != (cnt_clear || cnt_run))) n_inv++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Order in which a scan over mask m delivers results, repeated for each pass.
  function automatic iq_t model_order(input logic [NUM_RO-1:0] m, input int passes);
    iq_t q;
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < NUM_RO; i++)
        if (m[i]) q.push_back(i);
    return q;
  endfunction

  task automatic tick();
    @(posedge ACLK); #1;
    if (rnd_ready) res_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic start(input logic [NUM_RO-1:0] m, input int w, input logic cont);
    cfg_mask = m; cfg_window = WIN_W'(w); cfg_continuous = cont;
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!busy) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    tick(); tick();
    n_checks++; if ({ro_en, cnt_clear, cnt_run, busy, done, cfg_err, ifc.res_valid} !== '0) begin
      $display("FAIL reset_outputs: got ro_en=%b clr=%b run=%b busy=%b done=%b err=%b v=%b want all 0",
               ro_en, cnt_clear, cnt_run, busy, done, cfg_err, ifc.res_valid); n_fails++; end
    ARESETN = 1'b1; tick(); tick();
    n_checks++; if (busy !== 1'b0 || ro_en !== 4'b0000) begin
      $display("FAIL reset_release: got busy=%b ro_en=%b want 0/0000", busy, ro_en); n_fails++; end
  endtask

  task automatic test_single();
    int b0 = n_obs, d0 = n_done, lat, exp_lat;
    bit ok;
    res_ready = 1'b1;
    exp_lat = 1 + SETTLE_CYC + 100 + SYNC_LAT + 1;
    start(4'b0001, 100, 1'b0); lat = 1;
    while (!ifc.res_valid && lat < 400) begin tick(); lat++; end
    n_checks++; if (lat !== exp_lat) begin
      $display("FAIL single_latency: got %0d want %0d", lat, exp_lat); n_fails++; end
    wait_idle(50, ok);
    n_checks++; if (!ok || done !== 1'b1) begin
      $display("FAIL single_done: got idle=%0d done=%b want 1/1", ok, done); n_fails++; end
    tick();
    n_checks++; if (n_obs - b0 !== 1 || obs_idx[b0] !== 0 || obs_data[b0] !== 100) begin
      $display("FAIL single_result: got n=%0d idx=%0d data=%0d want 1/0/100",
               n_obs - b0, obs_idx[b0], obs_data[b0]); n_fails++; end
    n_checks++; if (n_done - d0 !== 1) begin
      $display("FAIL single_done_count: got %0d want 1", n_done - d0); n_fails++; end
  endtask

  task automatic test_sparse();
    int b0 = n_obs, r0 = n_ro, d0 = n_done;
    iq_t exp;
    bit ok;
    res_ready = 1'b1;
    exp = model_order(4'b1010, 1);
    start(4'b1010, 10, 1'b0);
    wait_idle(300, ok); tick();
    n_checks++; if (!ok || n_obs - b0 !== exp.size() || n_ro - r0 !== exp.size()) begin
      $display("FAIL sparse_count: got idle=%0d res=%0d en=%0d want 1/%0d/%0d",
               ok, n_obs - b0, n_ro - r0, exp.size(), exp.size()); n_fails++; end
    for (int i = 0; i < exp.size(); i++) begin
      n_checks++; if (obs_idx[b0+i] !== exp[i] || obs_data[b0+i] !== 10 || ro_seq[r0+i] !== (1 << exp[i])) begin
        $display("FAIL sparse_item%0d: got idx=%0d data=%0d ro_en=%0d want %0d/10/%0d",
                 i, obs_idx[b0+i], obs_data[b0+i], ro_seq[r0+i], exp[i], 1 << exp[i]); n_fails++; end
    end
    n_checks++; if (n_done - d0 !== 1) begin
      $display("FAIL sparse_done: got %0d want 1", n_done - d0); n_fails++; end
  endtask

  task automatic test_backpressure();
    int b0 = n_obs, r0 = n_ro, d0 = n_done, t, bad = 0, ri, rd;
    bit ok;
    res_ready = 1'b0;
    start(4'b0011, 20, 1'b0);
    t = 0; while (!ifc.res_valid && t < 200) begin tick(); t++; end
    ri = int'(ifc.res_idx); rd = int'(ifc.res_data);
    n_checks++; if (ifc.res_valid !== 1'b1 || ri !== 0 || rd !== 20) begin
      $display("FAIL bp_first: got v=%b idx=%0d data=%0d want 1/0/20", ifc.res_valid, ri, rd); n_fails++; end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ifc.res_valid !== 1'b1 || int'(ifc.res_idx) !== ri || int'(ifc.res_data) !== rd || ro_en !== '0) bad++;
    end
    n_checks++; if (bad !== 0) begin
      $display("FAIL bp_stable: got %0d unstable cycles want 0", bad); n_fails++; end
    cfg_stop = 1'b1; tick(); cfg_stop = 1'b0;
    n_checks++; if (ifc.res_valid !== 1'b1 || busy !== 1'b1) begin
      $display("FAIL bp_stop_hold: got v=%b busy=%b want 1/1", ifc.res_valid, busy); n_fails++; end
    res_ready = 1'b1;
    wait_idle(50, ok); tick();
    n_checks++; if (!ok || n_obs - b0 !== 1 || n_ro - r0 !== 1 || n_done - d0 !== 1) begin
      $display("FAIL bp_stop_end: got idle=%0d res=%0d en=%0d done=%0d want 1/1/1/1",
               ok, n_obs - b0, n_ro - r0, n_done - d0); n_fails++; end
  endtask

  task automatic test_continuous();
    int b0 = n_obs, v0, t;
    iq_t exp;
    res_ready = 1'b1;
    exp = model_order(4'b0101, 2);
    start(4'b0101, 8, 1'b1);
    t = 0; while (n_obs - b0 < 4 && t < 1000) begin tick(); t++; end
    t = 0; while (!(cnt_run && ro_en == 4'b0001) && t < 100) begin tick(); t++; end
    tick(); tick(); tick();
    n_checks++; if (cnt_run !== 1'b1 || ro_en !== 4'b0001) begin
      $display("FAIL cont_measuring: got run=%b ro_en=%b want 1/0001", cnt_run, ro_en); n_fails++; end
    cfg_stop = 1'b1; tick(); cfg_stop = 1'b0;
    n_checks++; if (ro_en !== 4'b0000 || cnt_run !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL cont_stop: got ro_en=%b run=%b done=%b busy=%b want 0000/0/1/0",
               ro_en, cnt_run, done, busy); n_fails++; end
    cfg_continuous = 1'b0;
    v0 = n_vrise;
    repeat (100) tick();
    n_checks++; if (n_obs - b0 !== exp.size() || n_vrise !== v0) begin
      $display("FAIL cont_count: got res=%0d extra_valid=%0d want %0d/0",
               n_obs - b0, n_vrise - v0, exp.size()); n_fails++; end
    for (int i = 0; i < exp.size(); i++) begin
      n_checks++; if (obs_idx[b0+i] !== exp[i] || obs_data[b0+i] !== 8) begin
        $display("FAIL cont_item%0d: got idx=%0d data=%0d want %0d/8",
                 i, obs_idx[b0+i], obs_data[b0+i], exp[i]); n_fails++; end
    end
  endtask

  task automatic test_bad_cfg();
    int b0;
    bit ok;
    start(4'b0011, 0, 1'b0);
    n_checks++; if (cfg_err !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL err_window: got err=%b busy=%b want 1/0", cfg_err, busy); n_fails++; end
    tick();
    n_checks++; if (cfg_err !== 1'b0) begin
      $display("FAIL err_pulse: got err=%b want 0", cfg_err); n_fails++; end
    start(4'b0000, 10, 1'b0);
    n_checks++; if (cfg_err !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL err_mask: got err=%b busy=%b want 1/0", cfg_err, busy); n_fails++; end
    cfg_stop = 1'b1; start(4'b0001, 10, 1'b0); cfg_stop = 1'b0;
    n_checks++; if (cfg_err !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL start_stop: got err=%b busy=%b want 0/0", cfg_err, busy); n_fails++; end
    res_ready = 1'b1; b0 = n_obs;
    start(4'b0001, 30, 1'b0);
    repeat (5) tick();
    cfg_mask = 4'b1111; cfg_window = 16'd5; cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    n_checks++; if (cfg_err !== 1'b0 || ro_en !== 4'b0001) begin
      $display("FAIL busy_start: got err=%b ro_en=%b want 0/0001", cfg_err, ro_en); n_fails++; end
    wait_idle(300, ok); tick();
    n_checks++; if (!ok || n_obs - b0 !== 1 || obs_idx[b0] !== 0 || obs_data[b0] !== 30) begin
      $display("FAIL busy_result: got idle=%0d n=%0d idx=%0d data=%0d want 1/1/0/30",
               ok, n_obs - b0, obs_idx[b0], obs_data[b0]); n_fails++; end
  endtask

  task automatic test_reset_mid();
    int b0, t;
    bit ok;
    res_ready = 1'b1;
    start(4'b0100, 200, 1'b0);
    t = 0; while (!cnt_run && t < 50) begin tick(); t++; end
    repeat (10) tick();
    #3 ARESETN = 1'b0;
    #1;
    n_checks++; if (ro_en !== 4'b0000 || cnt_run !== 1'b0 || ifc.res_valid !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL async_reset: got ro_en=%b run=%b v=%b busy=%b want 0000/0/0/0",
               ro_en, cnt_run, ifc.res_valid, busy); n_fails++; end
    tick(); ARESETN = 1'b1; tick();
    b0 = n_obs;
    start(4'b0100, 15, 1'b0);
    wait_idle(300, ok); tick();
    n_checks++; if (!ok || n_obs - b0 !== 1 || obs_idx[b0] !== 2 || obs_data[b0] !== 15) begin
      $display("FAIL post_reset: got idle=%0d n=%0d idx=%0d data=%0d want 1/1/2/15",
               ok, n_obs - b0, obs_idx[b0], obs_data[b0]); n_fails++; end
  endtask

  task automatic test_random();
    logic [NUM_RO-1:0] m;
    int w, b0, d0, bad;
    iq_t exp;
    bit ok;
    rnd_ready = 1'b1;
    for (int it = 0; it < 8; it++) begin
      m = NUM_RO'($urandom_range(1, 15));
      w = (it == 0) ? 1 : int'($urandom_range(1, 40));
      b0 = n_obs; d0 = n_done; bad = 0;
      exp = model_order(m, 1);
      start(m, w, 1'b0);
      cfg_mask = NUM_RO'($urandom); cfg_window = WIN_W'($urandom_range(0, 60));
      wait_idle(3000, ok); tick();
      n_checks++; if (!ok || n_obs - b0 !== exp.size() || n_done - d0 !== 1) begin
        $display("FAIL rand%0d_count: got idle=%0d res=%0d done=%0d want 1/%0d/1 (mask=%b win=%0d)",
                 it, ok, n_obs - b0, n_done - d0, exp.size(), m, w); n_fails++; end
      for (int i = 0; i < exp.size(); i++)
        if (obs_idx[b0+i] !== exp[i] || obs_data[b0+i] !== w) bad++;
      n_checks++; if (bad !== 0) begin
        $display("FAIL rand%0d_data: got %0d wrong results want 0 (mask=%b win=%0d)", it, bad, m, w); n_fails++; end
    end
    rnd_ready = 1'b0; res_ready = 1'b1;
  endtask

  task automatic test_onehot();
    n_checks++; if (n_inv !== 0) begin
      $display("FAIL ro_en_onehot: got %0d bad cycles want 0", n_inv); n_fails++; end
  endtask

  initial begin
    test_reset();
    test_single();
    test_sparse();
    test_backpressure();
    test_continuous();
    test_bad_cfg();
    test_reset_mid();
    test_random();
    test_onehot();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
